memory_responder: RTL and testbench

Bus-side responder for the CPU's address and data buses: when an address register drives the address bus and the control unit asserts a read or write strobe, this block latches the address and runs the memory or I/O access. It inserts a fixed number of wait states and reports completion with a `ready` handshake. It sits between the shared address/data buses and the RAM/ROM and I/O-port arrays, and is the consumer of every address the address registers assert.

---
 rtl/memory_responder_pkg.sv | 15 +
 rtl/memory_responder_wait_state_counter.sv | 21 ++
 rtl/memory_responder.sv | 110 +++++++++++
 tb/tb_memory_responder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the bus-side memory/I/O responder.
package memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Control-unit strobes are active low
  localparam logic STROBE_ACTIVE = 1'b0;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

endpackage

// File: rtl/memory_responder_wait_state_counter.sv
// 4-bit load/decrement wait-state counter; saturates at zero instead of wrapping.
module wait_state_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset)                   count <= 4'd0;
    else if (load)               count <= load_val;
    else if (dec && count != 0)  count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/memory_responder.sv
// Latches a strobed bus address, runs a fixed-wait memory or I/O access and
// signals completion with ready; rejected strobes in IDLE pulse bus_err.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(IO_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  addr_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_en,
  output logic                  ready,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic                  io_re,
  output logic                  io_we
);

  state_t state, next_state;
  logic   rd_act, wr_act, accept, reject, finish, cnt_zero;
  logic   is_read, is_io;

  assign rd_act = (read  == STROBE_ACTIVE);
  assign wr_act = (write == STROBE_ACTIVE);
  assign accept = (state == IDLE) && (rd_act ^ wr_act) && addr_valid;
  assign reject = (state == IDLE) && (rd_act | wr_act) && !accept;
  assign finish = (state == ACCESS) && cnt_zero;

  wait_state_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (4'(WAIT_STATES)),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)             next_state = ACCESS;
      ACCESS:  if (cnt_zero)           next_state = DONE;
      DONE:    if (!rd_act && !wr_act) next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // Outputs decode only registered state so strobe glitches never reach them
  always_comb begin
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    io_re   = 1'b0;
    io_we   = 1'b0;
    ready   = 1'b0;
    data_en = 1'b0;
    case (state)
      ACCESS: begin
        mem_re = is_read  && !is_io;
        mem_we = !is_read && !is_io;
        io_re  = is_read  &&  is_io;
        io_we  = !is_read &&  is_io;
      end
      DONE: begin
        ready   = 1'b1;
        data_en = is_read;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_out  <= '0;
      is_read   <= 1'b0;
      is_io     <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= reject;
      if (accept) begin
        mem_addr  <= addr_in;
        mem_wdata <= data_in;
        is_read   <= rd_act;
        is_io     <= (addr_in >= IO_BASE);
      end
      if (finish && is_read)
        data_out <= is_io ? io_rdata : mem_rdata;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: cycle table on a WAIT_STATES=2 instance, hand sequences on a WAIT_STATES=0 one.
module tb_memory_responder;

  logic        clk, reset, addr_valid, read, write;
  logic [15:0] addr_in;
  logic [7:0]  data_in, mem_rdata, io_rdata;

  logic [7:0]  data_out2, mem_wdata2, data_out0, mem_wdata0;
  logic [15:0] mem_addr2, mem_addr0;
  logic        data_en2, ready2, bus_err2, mem_re2, mem_we2, io_re2, io_we2;
  logic        data_en0, ready0, bus_err0, mem_re0, mem_we0, io_re0, io_we0;

  int checks = 0;
  int failures = 0;

  memory_responder #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .addr_in(addr_in), .addr_valid(addr_valid),
    .data_in(data_in), .read(read), .write(write), .data_out(data_out2),
    .data_en(data_en2), .ready(ready2), .bus_err(bus_err2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata), .io_rdata(io_rdata),
    .mem_re(mem_re2), .mem_we(mem_we2), .io_re(io_re2), .io_we(io_we2)
  );

  memory_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .addr_in(addr_in), .addr_valid(addr_valid),
    .data_in(data_in), .read(read), .write(write), .data_out(data_out0),
    .data_en(data_en0), .ready(ready0), .bus_err(bus_err0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .io_rdata(io_rdata),
    .mem_re(mem_re0), .mem_we(mem_we0), .io_re(io_re0), .io_we(io_we0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rd, wr, av;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [3:0]  en;    // {mem_re, mem_we, io_re, io_we}
    logic        rdy, den, berr;
    logic [7:0]  dout;
    logic [15:0] maddr;
    logic [7:0]  wdata;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic rst, rd, wr, av, input logic [15:0] addr,
                   input logic [7:0] din, input logic [3:0] en,
                   input logic rdy, den, berr, input logic [7:0] dout,
                   input logic [15:0] maddr, input logic [7:0] wdata);
    vec_t r;
    r.rst = rst; r.rd = rd; r.wr = wr; r.av = av; r.addr = addr; r.din = din;
    r.en = en; r.rdy = rdy; r.den = den; r.berr = berr; r.dout = dout;
    r.maddr = maddr; r.wdata = wdata;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; read = 1'b1; write = 1'b1; addr_valid = 1'b0;
    addr_in = 16'h0; data_in = 8'h0; mem_rdata = 8'hA5; io_rdata = 8'h5A;

    //   rst   rd    wr    av    addr      din    en    rdy   den   berr  dout   maddr     wdata
    v(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00); // 0 reset
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    v(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 4'h8, 1'b0, 1'b0, 1'b0, 8'h00, 16'h1234, 8'h00); // mem read
    v(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 4'h8, 1'b0, 1'b0, 1'b0, 8'h00, 16'h1234, 8'h00);
    v(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 4'h8, 1'b0, 1'b0, 1'b0, 8'h00, 16'h1234, 8'h00);
    v(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 8'hA5, 16'h1234, 8'h00); // DONE
    v(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 8'hA5, 16'h1234, 8'h00); // held
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'hA5, 16'h1234, 8'h00);
    v(1'b0, 1'b1, 1'b0, 1'b1, 16'hFF10, 8'h3C, 4'h1, 1'b0, 1'b0, 1'b0, 8'hA5, 16'hFF10, 8'h3C); // io write
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0, 8'hA5, 16'hFF10, 8'h3C);
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0, 8'hA5, 16'hFF10, 8'h3C);
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 8'hA5, 16'hFF10, 8'h3C);
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'hA5, 16'hFF10, 8'h3C);
    v(1'b0, 1'b0, 1'b0, 1'b1, 16'h0055, 8'h77, 4'h0, 1'b0, 1'b0, 1'b1, 8'hA5, 16'hFF10, 8'h3C); // both low
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'hA5, 16'hFF10, 8'h3C);
    v(1'b0, 1'b0, 1'b1, 1'b0, 16'h0066, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 8'hA5, 16'hFF10, 8'h3C); // no addr_valid
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'hA5, 16'hFF10, 8'h3C);
    v(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 8'h00, 4'h8, 1'b0, 1'b0, 1'b0, 8'hA5, 16'h0100, 8'h00);
    v(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00); // reset mid-access
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    v(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 8'h00, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, 8'h00); // io read
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, 8'h00);
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h2, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, 8'h00);
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 8'h5A, 16'hFFFF, 8'h00);
    v(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'h5A, 16'hFFFF, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; read = tbl[i].rd; write = tbl[i].wr;
      addr_valid = tbl[i].av; addr_in = tbl[i].addr; data_in = tbl[i].din;
      @(posedge clk); #1;
      chk($sformatf("row%0d_enables", i), {28'd0, mem_re2, mem_we2, io_re2, io_we2}, {28'd0, tbl[i].en});
      chk($sformatf("row%0d_ready", i), {31'd0, ready2}, {31'd0, tbl[i].rdy});
      chk($sformatf("row%0d_data_en", i), {31'd0, data_en2}, {31'd0, tbl[i].den});
      chk($sformatf("row%0d_bus_err", i), {31'd0, bus_err2}, {31'd0, tbl[i].berr});
      chk($sformatf("row%0d_data_out", i), {24'd0, data_out2}, {24'd0, tbl[i].dout});
      chk($sformatf("row%0d_mem_addr", i), {16'd0, mem_addr2}, {16'd0, tbl[i].maddr});
      chk($sformatf("row%0d_mem_wdata", i), {24'd0, mem_wdata2}, {24'd0, tbl[i].wdata});
    end

    // Zero wait states, strobe released while the access is in flight
    @(negedge clk);
    reset = 1'b0; read = 1'b0; write = 1'b1; addr_valid = 1'b1; addr_in = 16'h2000;
    @(posedge clk); #1;
    chk("ws0_access_mem_re", {31'd0, mem_re0}, 32'd1);
    chk("ws0_access_ready", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    read = 1'b1; addr_valid = 1'b0;
    @(posedge clk); #1;
    chk("ws0_done_mem_re", {31'd0, mem_re0}, 32'd0);
    chk("ws0_done_ready", {31'd0, ready0}, 32'd1);
    chk("ws0_done_data_out", {24'd0, data_out0}, 32'h0000_00A5);
    chk("ws0_done_data_en", {31'd0, data_en0}, 32'd1);
    @(posedge clk); #1;
    chk("ws0_idle_ready", {31'd0, ready0}, 32'd0);
    chk("ws0_idle_mem_re", {31'd0, mem_re0}, 32'd0);
    repeat (5) @(posedge clk);

    // Bounded wait for ready on the two-wait-state instance
    @(negedge clk);
    read = 1'b0; addr_valid = 1'b1; addr_in = 16'h0040;
    @(posedge clk); #1;
    n = 0;
    while (!ready2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ws2_ready_latency", n, 32'd3);
    @(negedge clk);
    read = 1'b1; addr_valid = 1'b0;
    @(posedge clk); #1;
    chk("ws2_release_ready", {31'd0, ready2}, 32'd0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
